seg_scan_mux: RTL

Parametrised multiplexed seven-segment display scanner for the stopwatch display path. It time-multiplexes NUM_DIGITS hex digits onto one shared active-low cathode bus and NUM_DIGITS active-low anodes. Each digit slot starts with an anti-ghosting blanking gap. Digit data is captured once per frame so the display never tears, and leading-zero suppression is optional. The block replaces a free-running 2-bit select plus fixed 4-anode decoder, and sits between the stopwatch BCD counters and the board display pins.

---
 rtl/seg_scan_mux.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner: one active-low anode at a time, a blank gap at the
// start of every slot, per-frame digit snapshots and optional leading-zero blanking.
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 2000,
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lz_en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   seg_an,
  output logic [6:0]              seg_cat,
  output logic                    seg_dp,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] snap_d_reg, snap_d_next;
  logic [NUM_DIGITS-1:0]   snap_dp_reg, snap_dp_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic [6:0]              cat_reg, cat_next;
  logic                    dp_reg, dp_next;
  logic [IDX_W-1:0]        didx_reg, didx_next;

  logic [3:0]            snap_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] suppress;
  logic                  all_zero;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_sup;
  logic [6:0]            decoded;
  logic                  capture;
  logic                  in_gap;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign snap_nib[gi] = snap_d_reg[4*gi +: 4];
    end
  endgenerate

  // A digit is blank-eligible when it and every more significant digit are zero.
  always_comb begin
    suppress = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero && (snap_nib[i] == 4'h0);
      suppress[i] = all_zero;
    end
  end

  assign cur_nib = snap_nib[idx_reg];
  assign cur_dp  = snap_dp_reg[idx_reg];
  assign cur_sup = lz_en && suppress[idx_reg];

  always_comb begin
    decoded = 7'h7F;
    case (cur_nib)
      4'h0: decoded = 7'b1000000;
      4'h1: decoded = 7'b1111001;
      4'h2: decoded = 7'b0100100;
      4'h3: decoded = 7'b0110000;
      4'h4: decoded = 7'b0011001;
      4'h5: decoded = 7'b0010010;
      4'h6: decoded = 7'b0000010;
      4'h7: decoded = 7'b1111000;
      4'h8: decoded = 7'b0000000;
      4'h9: decoded = 7'b0010000;
      4'hA: decoded = 7'b0001000;
      4'hB: decoded = 7'b0000011;
      4'hC: decoded = 7'b1000110;
      4'hD: decoded = 7'b0100001;
      4'hE: decoded = 7'b0000110;
      default: decoded = 7'b0001110;
    endcase
  end

  assign capture = enable && (cnt_reg == '0) && (idx_reg == '0);
  assign in_gap  = (cnt_reg < GAP_LIM);

  always_comb begin
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    snap_d_next  = snap_d_reg;
    snap_dp_next = snap_dp_reg;
    an_next      = '1;
    cat_next     = 7'h7F;
    dp_next      = 1'b1;
    didx_next    = '0;

    if (!enable) begin
      cnt_next = '0;
      idx_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    if (capture) begin
      snap_d_next  = digits_in;
      snap_dp_next = dp_in;
    end

    // Outputs describe the current state and appear one edge later.
    if (enable) begin
      didx_next = idx_reg;
      if (!in_gap) begin
        an_next  = ~(NUM_DIGITS'(1) << idx_reg);
        cat_next = cur_sup ? 7'h7F : decoded;
        dp_next  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      idx_reg     <= '0;
      snap_d_reg  <= '0;
      snap_dp_reg <= '0;
      an_reg      <= '1;
      cat_reg     <= 7'h7F;
      dp_reg      <= 1'b1;
      didx_reg    <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      snap_d_reg  <= snap_d_next;
      snap_dp_reg <= snap_dp_next;
      an_reg      <= an_next;
      cat_reg     <= cat_next;
      dp_reg      <= dp_next;
      didx_reg    <= didx_next;
    end
  end

  assign seg_an    = an_reg;
  assign seg_cat   = cat_reg;
  assign seg_dp    = dp_reg;
  assign digit_idx = didx_reg;

endmodule
